// File: rtl/nonogram_pkg.sv
// Shared constants, FSM state codes and line-table entry for the nonogram option store.
package nonogram_pkg;
    localparam int DATA_W    = 16;
    localparam int DEPTH     = 512;
    localparam int MAX_LINES = 22;
    localparam int AW        = $clog2(DEPTH);
    localparam int LW        = $clog2(MAX_LINES + 1);

    localparam logic [AW:0]   FULL_PTR     = (AW+1)'(DEPTH);
    localparam logic [LW-1:0] MAX_LINE_IDX = LW'(MAX_LINES);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    typedef struct packed {
        logic [AW-1:0] base;
        logic [AW:0]   count;
    } line_ent_t;
endpackage

// File: rtl/option_store_ram.sv
// Option memory: one write port, one synchronous read port with read enable.
module option_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Output only moves on a read, so a stalled beat holds its data.
    always_ff @(posedge i_clk) begin
        if (i_re)
            r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;
endmodule

// File: rtl/option_store.sv
// Captures per-line option words, keeps a base/count table per line and
// replays any line's options as a flow-controlled burst once the board is loaded.
module option_store
    import nonogram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] opt_data,
    input  logic              opt_valid,
    input  logic              opt_last,
    input  logic              board_done,
    input  logic              clear,
    output logic              loaded,
    output logic [LW-1:0]     num_lines,
    output logic              overflow,
    input  logic              rd_req,
    input  logic [LW-1:0]     rd_line,
    output logic              rd_busy,
    output logic              rd_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready
);
    logic [1:0]      r_state;
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_line_base;
    logic [AW:0]     r_cur_count;
    logic [LW-1:0]   r_line_idx;
    logic [LW-1:0]   r_num_lines;
    logic            r_loaded;
    logic            r_overflow;
    logic            r_rd_err;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_remaining;
    logic            r_valid;
    logic            r_last;
    line_ent_t       r_tbl [MAX_LINES];

    logic            w_fill;
    logic            w_wr_ok;
    logic [AW:0]     w_cnt_inc;
    logic            w_close;
    logic            w_line_ok;
    logic [LW-1:0]   w_line_idx_nx;
    logic            w_done;
    logic            w_overflow;
    logic            w_rd_ok;
    logic            w_issue;
    logic            w_final;
    logic [DATA_W-1:0] w_q;

    always_comb begin
        w_fill        = (r_state == ST_FILL);
        w_wr_ok       = w_fill && opt_valid && (r_wr_ptr != FULL_PTR);
        w_cnt_inc     = r_cur_count + (AW+1)'(w_wr_ok);
        w_close       = w_fill && opt_valid && opt_last;
        // A line with no stored words (memory already full) is not recorded.
        w_line_ok     = w_close && (r_line_idx != MAX_LINE_IDX) && (w_cnt_inc != '0);
        w_line_idx_nx = r_line_idx + LW'(w_line_ok);
        w_done        = w_fill && board_done;
        w_overflow    = (w_fill && opt_valid && !w_wr_ok)
                      || (w_close && !w_line_ok)
                      || (w_done && !w_close && (w_cnt_inc != '0));
        w_rd_ok       = rd_req && (r_state == ST_READY) && (rd_line < r_num_lines);
        w_issue       = (r_state == ST_READ) && (r_remaining != '0) && (!r_valid || rd_ready);
        w_final       = r_valid && rd_ready && r_last;
    end

    option_ram #(
        .DW    (DATA_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_wr_ok && !rst && !clear),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (opt_data),
        .i_re    (w_issue && !rst && !clear),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_q)
    );

    always_ff @(posedge clk) begin
        if (!rst && !clear && w_line_ok)
            r_tbl[r_line_idx] <= '{base: r_line_base[AW-1:0], count: w_cnt_inc};
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state     <= ST_FILL;
            r_wr_ptr    <= '0;
            r_line_base <= '0;
            r_cur_count <= '0;
            r_line_idx  <= '0;
            r_num_lines <= '0;
            r_loaded    <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_err    <= 1'b0;
            r_rd_ptr    <= '0;
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_rd_err <= rd_req && !w_rd_ok;
            if (w_overflow)
                r_overflow <= 1'b1;
            case (r_state)
                ST_FILL: begin
                    if (w_wr_ok)
                        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
                    r_cur_count <= w_close ? '0 : w_cnt_inc;
                    if (w_close)
                        r_line_base <= r_wr_ptr + (AW+1)'(w_wr_ok);
                    r_line_idx <= w_line_idx_nx;
                    if (w_done) begin
                        r_state     <= ST_READY;
                        r_loaded    <= 1'b1;
                        r_num_lines <= w_line_idx_nx;
                        r_cur_count <= '0;
                    end
                end
                ST_READY: begin
                    if (w_rd_ok) begin
                        r_state     <= ST_READ;
                        r_rd_ptr    <= r_tbl[rd_line].base;
                        r_remaining <= r_tbl[rd_line].count;
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        r_rd_ptr    <= r_rd_ptr + AW'(1);
                        r_remaining <= r_remaining - (AW+1)'(1);
                        r_valid     <= 1'b1;
                        r_last      <= (r_remaining == (AW+1)'(1));
                    end else if (r_valid && rd_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end
                    if (w_final)
                        r_state <= ST_READY;
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    assign loaded    = r_loaded;
    assign num_lines = r_num_lines;
    assign overflow  = r_overflow;
    assign rd_busy   = (r_state == ST_READ);
    assign rd_err    = r_rd_err;
    assign rd_valid  = r_valid;
    assign rd_last   = r_last;
    assign rd_data   = r_valid ? w_q : '0;
endmodule

// File: tb/tb_option_store.sv
// Scoreboard bench for option_store: directed loads, bursts, stalls, errors, overflow.
module tb_option_store;
    import nonogram_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] opt_data = '0;
    logic              opt_valid = 1'b0;
    logic              opt_last = 1'b0;
    logic              board_done = 1'b0;
    logic              clear = 1'b0;
    logic              loaded;
    logic [LW-1:0]     num_lines;
    logic              overflow;
    logic              rd_req = 1'b0;
    logic [LW-1:0]     rd_line = '0;
    logic              rd_busy;
    logic              rd_err;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              rd_ready = 1'b1;

    option_store dut (
        .clk(clk), .rst(rst), .opt_data(opt_data), .opt_valid(opt_valid),
        .opt_last(opt_last), .board_done(board_done), .clear(clear),
        .loaded(loaded), .num_lines(num_lines), .overflow(overflow),
        .rd_req(rd_req), .rd_line(rd_line), .rd_busy(rd_busy), .rd_err(rd_err),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DATA_W-1:0] d; logic l; } beat_t;
    beat_t sb_q[$];

    int checks = 0;
    int failures = 0;

    // Expected memory contents, tracked from the words the bench sends.
    logic [DATA_W-1:0] m_mem [DEPTH];
    int m_base [MAX_LINES];
    int m_cnt  [MAX_LINES];
    int m_wr, m_cur, m_lines, m_base_cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_wr = 0; m_cur = 0; m_lines = 0; m_base_cur = 0;
        sb_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input bit last, input bit done);
        opt_data = d; opt_valid = 1'b1; opt_last = last; board_done = done;
        if (m_wr < DEPTH) begin
            m_mem[m_wr] = d; m_wr++; m_cur++;
        end
        if (last) begin
            if (m_lines < MAX_LINES && m_cur > 0) begin
                m_base[m_lines] = m_base_cur; m_cnt[m_lines] = m_cur; m_lines++;
            end
            m_base_cur = m_wr; m_cur = 0;
        end
        if (done) m_cur = 0;
        tick();
        opt_valid = 1'b0; opt_last = 1'b0; board_done = 1'b0;
    endtask

    task automatic push_line(input int ln);
        for (int k = 0; k < m_cnt[ln]; k++) begin
            beat_t b;
            b.d = m_mem[m_base[ln] + k];
            b.l = (k == m_cnt[ln] - 1);
            sb_q.push_back(b);
        end
    endtask

    // Consumes cnt beats, optionally stalling a chosen beat; enforces a cycle budget.
    task automatic drain(input int cnt, input int stall_beat, input int stall_n, input bit chk_timing);
        int beat = 0;
        int cyc = 0;
        int left = stall_n;
        int first = -1;
        logic v;
        while (beat < cnt && cyc < 4 * cnt + 40) begin
            v = rd_valid;
            if (v && first < 0) first = cyc;
            if (v && beat == stall_beat && left > 0) begin
                rd_ready = 1'b0; left--;
            end else begin
                rd_ready = 1'b1;
            end
            tick();
            cyc++;
            if (v && rd_ready) beat++;
        end
        rd_ready = 1'b1;
        check("burst_beats", beat, cnt);
        if (chk_timing) begin
            check("first_valid_latency", first, 1);
            check("back_to_back_cycles", cyc, cnt + 1);
        end
        check("busy_after_burst", rd_busy, 1'b0);
        check("sb_empty", sb_q.size(), 0);
    endtask

    task automatic read_line(input int ln, input int stall_beat, input int stall_n, input bit chk_timing);
        push_line(ln);
        rd_line = LW'(ln);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        if (chk_timing) begin
            check("valid_not_early", rd_valid, 1'b0);
            check("busy_after_accept", rd_busy, 1'b1);
        end
        drain(m_cnt[ln], stall_beat, stall_n, chk_timing);
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_d;
    logic              prev_l;
    always @(negedge clk) begin
        if (prev_stall) begin
            check("stall_hold_valid", rd_valid, 1'b1);
            check("stall_hold_data", rd_data, prev_d);
            check("stall_hold_last", rd_last, prev_l);
        end
        if (!rst && rd_valid && rd_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", rd_data, 32'hFFFF_FFFF);
            end else begin
                beat_t b;
                b = sb_q.pop_front();
                check("beat_data", rd_data, b.d);
                check("beat_last", rd_last, b.l);
            end
        end
        prev_stall = rd_valid && !rd_ready && !rst && !clear;
        prev_d = rd_data;
        prev_l = rd_last;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int cnts [8] = '{1, 2, 2, 1, 1, 2, 2, 1};

    initial begin
        model_reset();
        do_reset();
        check("rst_loaded", loaded, 1'b0);
        check("rst_num_lines", num_lines, 0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_busy", rd_busy, 1'b0);
        check("rst_rd_err", rd_err, 1'b0);

        // 4x4 board: 8 lines
        for (int ln = 0; ln < 8; ln++)
            for (int k = 0; k < cnts[ln]; k++)
                send((ln == 0) ? 16'h000F : {4'hC, 4'(ln), 4'(k), 4'h5}, k == cnts[ln] - 1, 1'b0);
        check("fill_not_loaded", loaded, 1'b0);
        board_done = 1'b1; tick(); board_done = 1'b0;
        check("load_loaded", loaded, 1'b1);
        check("load_num_lines", num_lines, 8);
        check("load_overflow", overflow, 1'b0);

        read_line(1, -1, 0, 1'b1);
        read_line(1, 0, 3, 1'b0);
        read_line(0, -1, 0, 1'b1);
        read_line(7, 1, 2, 1'b0);
        read_line(3, -1, 0, 1'b0);
        read_line(6, 1, 1, 1'b0);

        // writes and board_done outside FILL are ignored
        send(16'hDEAD, 1'b1, 1'b1);
        check("ready_ignore_num_lines", num_lines, 8);
        m_lines = 8;
        read_line(0, -1, 0, 1'b0);

        // out-of-range index
        rd_line = LW'(8); rd_req = 1'b1; tick(); rd_req = 1'b0;
        check("oob_rd_err", rd_err, 1'b1);
        check("oob_busy", rd_busy, 1'b0);
        tick();
        check("oob_rd_err_pulse", rd_err, 1'b0);

        // request while busy
        push_line(2);
        rd_ready = 1'b0; rd_line = LW'(2); rd_req = 1'b1; tick(); rd_req = 1'b0;
        tick();
        rd_line = '0; rd_req = 1'b1; tick(); rd_req = 1'b0;
        check("busy_rd_err", rd_err, 1'b1);
        check("busy_still_busy", rd_busy, 1'b1);
        tick();
        check("busy_rd_err_pulse", rd_err, 1'b0);
        drain(2, -1, 0, 1'b0);

        // clear mid-burst
        rd_ready = 1'b0; rd_line = LW'(6); rd_req = 1'b1; tick(); rd_req = 1'b0;
        tick();
        check("pre_clear_valid", rd_valid, 1'b1);
        clear = 1'b1; tick(); clear = 1'b0;
        model_reset();
        rd_ready = 1'b1;
        check("clear_rd_valid", rd_valid, 1'b0);
        check("clear_busy", rd_busy, 1'b0);
        check("clear_loaded", loaded, 1'b0);
        rd_line = '0; rd_req = 1'b1; tick(); rd_req = 1'b0;
        check("fill_rd_err", rd_err, 1'b1);

        // new 2-line board, last word shares the cycle with board_done
        send(16'hBEEF, 1'b1, 1'b0);
        send(16'h1234, 1'b0, 1'b0);
        send(16'h5678, 1'b1, 1'b1);
        check("new_loaded", loaded, 1'b1);
        check("new_num_lines", num_lines, 2);
        check("new_overflow", overflow, 1'b0);
        read_line(0, -1, 0, 1'b1);
        read_line(1, -1, 0, 1'b0);

        // overflow: 21 lines x 24 words + 9-word line = DEPTH+1 words
        do_reset();
        for (int ln = 0; ln < 22; ln++) begin
            int n = (ln < 21) ? 24 : 9;
            for (int k = 0; k < n; k++) begin
                if (ln == 21 && k == 8)
                    check("full_no_overflow_yet", overflow, 1'b0);
                send(16'(ln * 100 + k + 1), k == n - 1, 1'b0);
            end
        end
        check("ovf_set", overflow, 1'b1);
        board_done = 1'b1; tick(); board_done = 1'b0;
        check("ovf_num_lines", num_lines, 22);
        check("ovf_line21_cnt", m_cnt[21], 8);
        for (int ln = 0; ln < 22; ln++)
            read_line(ln, -1, 0, 1'b0);
        do_reset();
        check("ovf_rst_overflow", overflow, 1'b0);
        check("ovf_rst_loaded", loaded, 1'b0);

        // partial line at board_done is discarded
        send(16'hAAAA, 1'b1, 1'b0);
        send(16'h5555, 1'b0, 1'b1);
        check("partial_num_lines", num_lines, 1);
        check("partial_overflow", overflow, 1'b1);
        read_line(0, -1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/option_store.md
Name: option_store

Overview:
- Sits directly downstream of the byte parser in the nonogram loader path.
- Captures the stream of per-line option words (the legal fill patterns for each row/column), one word per cycle, into an on-chip option memory.
- Builds a base/count table per line index and, once the board is complete, serves any line's options to the solver as a flow-controlled burst.

Parameters:
- DATA_W, 16, width of one option word (matches the parser line output).
- DEPTH, 512, total option words storable across all lines.
- MAX_LINES, 22, maximum row+column count (11x11 board).
- AW, $clog2(DEPTH), option memory address width.
- LW, $clog2(MAX_LINES+1), line index/count width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- opt_data  in  DATA_W  option word from parser
- opt_valid  in  1  opt_data valid this cycle (parser write_ready)
- opt_last  in  1  qualifies opt_valid: word is last option of current line
- board_done  in  1  parser finished whole board (single-cycle pulse)
- clear  in  1  discard stored board, return to FILL
- loaded  out  1  board complete, reads permitted
- num_lines  out  LW  lines stored (valid when loaded)
- overflow  out  1  sticky: word or line dropped for lack of space
- rd_req  in  1  request burst for line rd_line
- rd_line  in  LW  line index to read
- rd_busy  out  1  burst in progress
- rd_err  out  1  one-cycle pulse: rd_req rejected
- rd_data  out  DATA_W  option word
- rd_valid  out  1  rd_data valid
- rd_last  out  1  with rd_valid: final option of line
- rd_ready  in  1  solver accepts rd_data this cycle

Behaviour:
- Reset and clear: all outputs 0, state FILL, wr_ptr=0, line_idx=0, line_base=0, cur_count=0, overflow cleared. Tables are not cleared; they are invalid until rewritten. clear has priority over every other input except rst.
- States: FILL, READY, READ.
- FILL: each opt_valid writes mem[wr_ptr] and increments wr_ptr and cur_count. On opt_valid && opt_last: base_tbl[line_idx]=line_base, cnt_tbl[line_idx]=cur_count+1, line_idx++, line_base=wr_ptr+1, cur_count=0.
- Full memory (wr_ptr==DEPTH): the word is dropped and overflow is set.
- opt_last when line_idx==MAX_LINES: the line is dropped and overflow is set.
- board_done in FILL: go to READY, num_lines=line_idx, loaded=1 next cycle. A word arriving in the same cycle is committed first.
- A partially received line (no opt_last yet) at board_done is discarded and sets overflow.
- opt_valid outside FILL is ignored. board_done outside FILL is ignored.
- READY: rd_req with rd_line<num_lines: go to READ, rd_busy=1 next cycle, rd_ptr=base_tbl[rd_line], remaining=cnt_tbl[rd_line].
- rd_req rejected (index out of range, state FILL, or state READ): rd_err pulses the next cycle; no other change.
- Option memory is synchronous-read (BRAM-inferable).
- Read timing: first rd_valid is exactly 2 cycles after the accepted rd_req. With rd_ready held high, beats follow on consecutive cycles.
- Stall: rd_data, rd_valid and rd_last hold stable while rd_valid && !rd_ready. After rd_ready re-asserts, at most one bubble cycle is permitted.
- Completion: rd_last is asserted with the final beat. When that beat is accepted, the state returns to READY and rd_busy drops the next cycle.
- Repeat reads of any line in any order are allowed; contents are unchanged until clear or rst.
- rst or clear during READ aborts the burst immediately; rd_valid=0 next cycle.

Decomposition:
- Package nonogram_pkg holds MAX_LINES, DATA_W, the state enum, and the line-table entry struct {base: AW, count: AW+1}.
- One sub-module, option_ram: single-port-write, single-port-read synchronous memory, DEPTH x DATA_W. The tables remain registers inside option_store.

Test Plan:
- 4x4 board; lines 0..7 carry option counts {1,2,2,1,1,2,2,1}; line 0 option 16'h000F; board_done -> loaded=1, num_lines=8, overflow=0.
- After that load, rd_req rd_line=1 with rd_ready=1 -> rd_valid 2 cycles later; 2 consecutive beats with the written values in order; rd_last on beat 2; rd_busy low afterwards.
- Same read with rd_ready low for 3 cycles on beat 1 -> rd_data stable throughout; no beat lost or duplicated; rd_last only on beat 2.
- rd_req rd_line=8 after loading 8 lines, and rd_req while rd_busy -> rd_err one-cycle pulse each; state and data unaffected.
- Write DEPTH+1 words across lines -> overflow=1; the first DEPTH words read back correctly; rst clears overflow and loaded.
- clear mid-burst, then a new 2-line board loaded -> rd_valid drops next cycle; num_lines=2; line 0 returns new data, not old.
